// File: rtl/spi_fpu_framer.sv
// Frames SPI bytes into an FPU command (opcode, A, B) and streams the FPU result back MSB-first.
// Optional status byte ahead of the result: define SPI_FPU_FRAMER_STATUS_EN.
module spi_fpu_framer #(
  parameter int OPERAND_BYTES = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         active,
  input  logic                         in_data_valid,
  input  logic [7:0]                   in_data,
  output logic                         out_data_valid,
  output logic [7:0]                   out_data,
  input  logic                         out_data_ready,
  output logic                         op_valid,
  input  logic                         op_ready,
  output logic [7:0]                   op_code,
  output logic [8*OPERAND_BYTES-1:0]   op_a,
  output logic [8*OPERAND_BYTES-1:0]   op_b,
  input  logic                         result_valid,
  input  logic [8*OPERAND_BYTES-1:0]   result,
  output logic                         result_ready,
  output logic                         busy,
  output logic                         overrun,
  output logic                         frame_abort
);

  localparam int W           = 8 * OPERAND_BYTES;
  localparam int FRAME_BYTES = 1 + 2 * OPERAND_BYTES;
  localparam int CNT_W       = $clog2(2 * OPERAND_BYTES + 2);
  localparam int TXC_W       = $clog2(OPERAND_BYTES + 2);
`ifdef SPI_FPU_FRAMER_STATUS_EN
  localparam int TX_BYTES    = OPERAND_BYTES + 1;
`else
  localparam int TX_BYTES    = OPERAND_BYTES;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_ISSUE,
    S_WAIT,
    S_TX
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         op_code_q, op_code_d;
  logic [2*W-1:0]     opnd_q, opnd_d;
  logic [W-1:0]       tx_q, tx_d;
  logic [TXC_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic               overrun_q, overrun_d;
  logic               frame_abort_q, frame_abort_d;
  logic               drop;
  logic               status_phase;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_code_q     <= '0;
      opnd_q        <= '0;
      tx_q          <= '0;
      tx_cnt_q      <= '0;
      overrun_q     <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_code_q     <= op_code_d;
      opnd_q        <= opnd_d;
      tx_q          <= tx_d;
      tx_cnt_q      <= tx_cnt_d;
      overrun_q     <= overrun_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  // The receiver cannot be back-pressured, so bytes outside IDLE/COLLECT are lost.
  assign drop = in_data_valid &&
                ((state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_TX));

`ifdef SPI_FPU_FRAMER_STATUS_EN
  assign status_phase = (state_q == S_TX) && (tx_cnt_q == TXC_W'(TX_BYTES));
`else
  assign status_phase = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_code_d     = op_code_q;
    opnd_d        = opnd_q;
    tx_d          = tx_q;
    tx_cnt_d      = tx_cnt_q;
    overrun_d     = overrun_q;
    frame_abort_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_data_valid && active) begin
          op_code_d = in_data;
          opnd_d    = '0;
          cnt_d     = CNT_W'(1);
          state_d   = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // A byte in the same cycle as chip-select falling still counts.
        if (in_data_valid) begin
          opnd_d = {opnd_q[2*W-9:0], in_data};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_BYTES - 1)) begin
            state_d = S_ISSUE;
          end
        end else if (!active) begin
          cnt_d         = '0;
          frame_abort_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (op_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (result_valid) begin
          tx_d     = result;
          tx_cnt_d = TXC_W'(TX_BYTES);
          state_d  = S_TX;
        end
      end
      S_TX: begin
        if (out_data_ready) begin
          if (!status_phase) begin
            tx_d = {tx_q[W-9:0], 8'h00};
          end
          tx_cnt_d = tx_cnt_q - TXC_W'(1);
          if (tx_cnt_q == TXC_W'(1)) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A fresh drop outranks the clear from sending the status byte.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (status_phase && out_data_ready) begin
      overrun_d = 1'b0;
    end
  end

`ifdef SPI_FPU_FRAMER_STATUS_EN
  assign out_data = status_phase ? {overrun_q, 3'b000, op_code_q[3:0]} : tx_q[W-1 -: 8];
`else
  assign out_data = tx_q[W-1 -: 8];
`endif

  assign out_data_valid = (state_q == S_TX);
  assign op_valid       = (state_q == S_ISSUE);
  assign result_ready   = (state_q == S_WAIT);
  assign busy           = (state_q != S_IDLE);
  assign op_code        = op_code_q;
  assign op_a           = opnd_q[2*W-1:W];
  assign op_b           = opnd_q[W-1:0];
  assign overrun        = overrun_q;
  assign frame_abort    = frame_abort_q;

endmodule

// File: tb/tb_spi_fpu_framer.sv
// Randomized bench for spi_fpu_framer: byte-level frame model, FPU stand-in and tx scoreboard.
// Honors SPI_FPU_FRAMER_STATUS_EN to expect the leading status byte.
module tb_spi_fpu_framer;

  localparam int OB = 4;
  localparam int W  = 8 * OB;

  logic          clock = 1'b0;
  logic          reset;
  logic          active;
  logic          in_data_valid;
  logic [7:0]    in_data;
  logic          out_data_valid;
  logic [7:0]    out_data;
  logic          out_data_ready;
  logic          op_valid;
  logic          op_ready;
  logic [7:0]    op_code;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          result_valid;
  logic [W-1:0]  result;
  logic          result_ready;
  logic          busy;
  logic          overrun;
  logic          frame_abort;

  int n_cmp = 0;
  int n_bad = 0;
  logic model_ovr = 1'b0;
  logic [7:0] exp_bytes[$];

  spi_fpu_framer #(.OPERAND_BYTES(OB)) dut (
    .clock          (clock),
    .reset          (reset),
    .active         (active),
    .in_data_valid  (in_data_valid),
    .in_data        (in_data),
    .out_data_valid (out_data_valid),
    .out_data       (out_data),
    .out_data_ready (out_data_ready),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_code        (op_code),
    .op_a           (op_a),
    .op_b           (op_b),
    .result_valid   (result_valid),
    .result         (result),
    .result_ready   (result_ready),
    .busy           (busy),
    .overrun        (overrun),
    .frame_abort    (frame_abort)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic act);
    in_data_valid = 1'b1;
    in_data       = b;
    active        = act;
    tick();
    in_data_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_odv"}, out_data_valid, 0);
    check({tag, "_od"}, out_data, 0);
    check({tag, "_opv"}, op_valid, 0);
    check({tag, "_opc"}, op_code, 0);
    check({tag, "_opa"}, op_a, 0);
    check({tag, "_opb"}, op_b, 0);
    check({tag, "_rr"}, result_ready, 0);
    check({tag, "_ovr"}, overrun, 0);
    check({tag, "_abort"}, frame_abort, 0);
  endtask

  // Pulls up to 'limit' bytes with random ready, checking order and hold-while-stalled.
  task automatic receive(input int limit);
    int got = 0;
    int cyc = 0;
    logic held = 1'b0;
    logic [7:0] held_b = 8'h00;
    logic rdy;
    while (got < limit && cyc < 300) begin
      if (out_data_valid) begin
        if (held) check("tx_hold", out_data, held_b);
        rdy = 1'($urandom_range(0, 1));
        out_data_ready = rdy;
        if (rdy) begin
          check("tx_byte", out_data, exp_bytes[got]);
          got++;
          held = 1'b0;
`ifdef SPI_FPU_FRAMER_STATUS_EN
          if (got == 1) model_ovr = 1'b0;
`endif
        end else begin
          held   = 1'b1;
          held_b = out_data;
        end
      end else begin
        out_data_ready = 1'b0;
      end
      tick();
      cyc++;
    end
    out_data_ready = 1'b0;
    check("tx_count", got, limit);
  endtask

  task automatic run_frame(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] res, input bit last_inactive, input bit drop_wait,
                           input int op_stall, input int tx_stall, input int tx_limit);
    logic [7:0] fb[2*OB+1];
    int lim;
    fb[0] = op;
    for (int i = 0; i < OB; i++) begin
      fb[1+i]    = a[W-1-8*i -: 8];
      fb[1+OB+i] = b[W-1-8*i -: 8];
    end
    $display("frame op=%02h a=%08h b=%08h res=%08h csfall=%0d drop=%0d", op, a, b, res,
             last_inactive, drop_wait);
    for (int i = 0; i < 2*OB+1; i++) begin
      active = 1'b1;
      repeat ($urandom_range(0, 2)) tick();
      check("op_valid_early", op_valid, 0);
      send_byte(fb[i], (i == 2*OB && last_inactive) ? 1'b0 : 1'b1);
    end
    check("op_valid", op_valid, 1);
    check("no_abort", frame_abort, 0);
    repeat (op_stall) tick();
    check("op_valid_held", op_valid, 1);
    check("op_code", op_code, op);
    check("op_a", op_a, a);
    check("op_b", op_b, b);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check("op_valid_drop", op_valid, 0);
    check("result_ready", result_ready, 1);
    if (drop_wait) begin
      in_data_valid = 1'b1;
      in_data       = 8'($urandom);
      active        = 1'($urandom_range(0, 1));
      tick();
      in_data_valid = 1'b0;
      model_ovr     = 1'b1;
      check("overrun_set", overrun, 1);
    end
    repeat ($urandom_range(0, 3)) tick();
    result_valid = 1'b1;
    result       = res;
    tick();
    result_valid = 1'b0;
    check("result_ready_drop", result_ready, 0);
    check("tx_valid", out_data_valid, 1);
    exp_bytes.delete();
`ifdef SPI_FPU_FRAMER_STATUS_EN
    exp_bytes.push_back({model_ovr, 3'b000, op[3:0]});
`endif
    for (int i = 0; i < OB; i++) exp_bytes.push_back(res[W-1-8*i -: 8]);
    if (tx_stall > 0) begin
      repeat (tx_stall) tick();
      check("tx_stall_valid", out_data_valid, 1);
      check("tx_stall_data", out_data, exp_bytes[0]);
    end
    lim = (tx_limit > 0) ? tx_limit : exp_bytes.size();
    receive(lim);
    if (tx_limit == 0) begin
      check("busy_done", busy, 0);
      check("tx_valid_done", out_data_valid, 0);
      check("overrun_after", overrun, model_ovr);
    end
  endtask

  task automatic abort_partial(input int k);
    active = 1'b1;
    for (int i = 0; i < k; i++) send_byte(8'($urandom), 1'b1);
    check("abort_busy_before", busy, 1);
    active = 1'b0;
    tick();
    check("abort_pulse", frame_abort, 1);
    check("abort_busy", busy, 0);
    tick();
    check("abort_pulse_end", frame_abort, 0);
    active = 1'b1;
    $display("abort after %0d bytes", k);
  endtask

  initial begin
    reset = 1'b1; active = 1'b0; in_data_valid = 1'b0; in_data = 8'h00;
    out_data_ready = 1'b0; op_ready = 1'b0; result_valid = 1'b0; result = '0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    run_frame(8'h01, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 20, 20, 0);

    abort_partial(3);
    run_frame(8'($urandom), $urandom, $urandom, $urandom, 0, 0, 2, 0, 0);

    run_frame(8'h05, $urandom, $urandom, 32'hC0DEBEEF, 0, 1, 1, 0, 0);

    // A byte while deselected in IDLE changes nothing.
    send_byte(8'hAA, 1'b0);
    check("idle_ignore_busy", busy, 0);
    check("idle_ignore_ovr", overrun, model_ovr);

    run_frame(8'h07, $urandom, $urandom, $urandom, 0, 0, 0, 0, 2);
    #2 reset = 1'b1;
    #1 check_all_zero("reset_tx");
    #3 reset = 1'b0;
    model_ovr = 1'b0;
    tick();
    run_frame(8'h02, $urandom, $urandom, $urandom, 0, 0, 0, 0, 0);

    run_frame(8'h03, $urandom, $urandom, $urandom, 1, 0, 1, 0, 0);

    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 3) == 0) abort_partial($urandom_range(1, 2*OB));
      run_frame(8'($urandom), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), $urandom_range(0, 4), $urandom_range(0, 3), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
